uart_boot_loader: RTL and testbench

// - Sits upstream of the system bus, between the UART RX byte stream and data memory.
// - Receives a framed program image, packs bytes into 32-bit words and writes them to memory as a system-bus master.
// - Holds the CPU in reset until the image is loaded and its checksum passes.
// - Frame, little-endian words: LEN (word count), BASE (byte address), LEN payload words, CSUM (XOR of payload words).

---
 rtl/boot_pkg.sv | 13 +
 rtl/boot_word_packer.sv | 31 +++
 rtl/uart_boot_loader.sv | 132 +++++++++++++
 tb/tb_uart_boot_loader.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/boot_pkg.sv
// boot_pkg: shared types and constants for the UART boot loader.
package boot_pkg;
  localparam int BOOT_WORD_BYTES = 4;
  typedef enum logic [2:0] {S_LEN, S_ADDR, S_DATA, S_CSUM, S_DONE, S_ERR} boot_state_e;
  typedef enum logic [2:0] {
    ERR_NONE    = 3'd0,
    ERR_LEN     = 3'd1,
    ERR_ALIGN   = 3'd2,
    ERR_OVERRUN = 3'd3,
    ERR_TIMEOUT = 3'd4,
    ERR_CSUM    = 3'd5
  } boot_err_e;
endpackage

// File: rtl/boot_word_packer.sv
// boot_word_packer: assembles little-endian bytes into 32-bit words.
module boot_word_packer
  import boot_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  i_data,
  input  logic        i_valid,
  input  logic        i_clr,
  output logic [31:0] o_word,
  output logic        o_vld,
  output logic [1:0]  o_cnt
);
  logic [1:0]  r_cnt;
  logic [23:0] r_sh;
  // Earlier bytes shift down so the newest lands on top when the word closes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_sh  <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_valid) begin
      r_cnt <= r_cnt + 2'd1;
      r_sh  <= {i_data, r_sh[23:8]};
    end
  end
  assign o_word = {i_data, r_sh};
  assign o_vld  = i_valid && (r_cnt == 2'(BOOT_WORD_BYTES - 1));
  assign o_cnt  = r_cnt;
endmodule

// File: rtl/uart_boot_loader.sv
// uart_boot_loader: loads a framed UART image into memory over the system bus
// and holds the CPU in reset until the image checksum passes.
module uart_boot_loader
  import boot_pkg::*;
#(
  parameter int MAX_WORDS   = 8192,
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  input  logic        restart,
  input  logic        bus_gnt,
  output logic        bus_en,
  output logic        bus_rdwr,
  output logic [3:0]  bus_mask,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wr_data,
  output logic        cpu_hold,
  output logic        done,
  output logic        error,
  output logic [2:0]  err_code
);
  localparam int RW = $clog2(MAX_WORDS + 1);
  localparam int TW = $clog2(TIMEOUT_CYC);

  boot_state_e r_state, w_nxt;
  boot_err_e   r_err, w_ecode;
  logic [RW-1:0] r_rem;
  logic [TW-1:0] r_to;
  logic [31:0] r_ptr, r_hold, r_csum, w_word;
  logic        r_pend, w_vld, w_gnt, w_tact, w_to, w_loading;
  logic [1:0]  w_cnt;

  assign w_loading = (r_state != S_DONE) && (r_state != S_ERR);
  assign w_gnt     = r_pend && bus_gnt;
  assign w_tact    = (r_state inside {S_ADDR, S_DATA, S_CSUM}) || (r_state == S_LEN && w_cnt != 2'd0);
  assign w_to      = w_tact && (r_to == TW'(TIMEOUT_CYC - 1));

  boot_word_packer u_packer (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_data  (rx_data),
    .i_valid (rx_valid && w_loading),
    .i_clr   (w_nxt != r_state),
    .o_word  (w_word),
    .o_vld   (w_vld),
    .o_cnt   (w_cnt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_LEN;
    else        r_state <= w_nxt;
  end

  // A completed word while the holding register is still busy and ungranted is an overrun.
  always_comb begin
    w_nxt   = r_state;
    w_ecode = ERR_NONE;
    if (w_to) begin
      w_nxt   = S_ERR;
      w_ecode = ERR_TIMEOUT;
    end else if (w_vld) begin
      case (r_state)
        S_LEN: begin
          w_nxt   = (w_word == 32'd0 || w_word > 32'(MAX_WORDS)) ? S_ERR : S_ADDR;
          w_ecode = ERR_LEN;
        end
        S_ADDR: begin
          w_nxt   = (w_word[1:0] != 2'd0) ? S_ERR : S_DATA;
          w_ecode = ERR_ALIGN;
        end
        S_DATA: begin
          w_nxt   = (r_pend && !bus_gnt) ? S_ERR : (r_rem == RW'(1)) ? S_CSUM : S_DATA;
          w_ecode = ERR_OVERRUN;
        end
        S_CSUM: begin
          w_nxt   = (r_pend && !bus_gnt) ? S_ERR : (w_word == r_csum) ? S_DONE : S_ERR;
          w_ecode = (r_pend && !bus_gnt) ? ERR_OVERRUN : ERR_CSUM;
        end
        default: w_nxt = r_state;
      endcase
    end else if (restart && !w_loading) begin
      w_nxt = S_LEN;
    end
  end

  always_comb begin
    done        = r_state == S_DONE;
    error       = r_state == S_ERR;
    cpu_hold    = r_state != S_DONE;
    bus_en      = r_pend;
    bus_rdwr    = r_pend;
    bus_mask    = r_pend ? 4'hF : 4'h0;
    bus_addr    = r_ptr;
    bus_wr_data = r_hold;
    err_code    = r_err;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err  <= ERR_NONE;
      r_rem  <= '0;
      r_to   <= '0;
      r_ptr  <= '0;
      r_hold <= '0;
      r_csum <= '0;
      r_pend <= 1'b0;
    end else begin
      r_err <= (w_nxt != S_ERR) ? ERR_NONE : (r_state == S_ERR) ? r_err : w_ecode;
      r_to  <= (rx_valid || !w_tact) ? '0 : r_to + 1'b1;
      if (r_state == S_LEN && w_vld) r_rem <= w_word[RW-1:0];
      if (r_state == S_ADDR && w_vld) begin
        r_ptr  <= w_word;
        r_csum <= '0;
      end else if (w_gnt) begin
        r_ptr <= r_ptr + 32'd4;
      end
      if (w_nxt == S_ERR) begin
        r_pend <= 1'b0;
      end else if (r_state == S_DATA && w_vld) begin
        r_hold <= w_word;
        r_pend <= 1'b1;
        r_csum <= r_csum ^ w_word;
        r_rem  <= r_rem - RW'(1);
      end else if (w_gnt) begin
        r_pend <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_uart_boot_loader.sv
// tb_uart_boot_loader: scoreboard bench for the UART boot loader.
module tb_uart_boot_loader;
  localparam int TO = 100;
  logic clk = 0, rst_n = 0, rx_valid = 0, restart = 0, bus_gnt = 1;
  logic [7:0] rx_data = 0;
  logic bus_en, bus_rdwr, cpu_hold, done, error;
  logic [3:0] bus_mask;
  logic [31:0] bus_addr, bus_wr_data;
  logic [2:0] err_code;
  int total = 0, bad = 0;
  logic [63:0] exp_q[$];
  logic [63:0] e;
  logic en_seen = 0;

  uart_boot_loader #(.MAX_WORDS(8192), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid), .restart(restart),
    .bus_gnt(bus_gnt), .bus_en(bus_en), .bus_rdwr(bus_rdwr), .bus_mask(bus_mask),
    .bus_addr(bus_addr), .bus_wr_data(bus_wr_data), .cpu_hold(cpu_hold), .done(done),
    .error(error), .err_code(err_code)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n && bus_en) begin
      en_seen = 1;
      if (bus_gnt) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL bus_write: unexpected write addr=%h data=%h", bus_addr, bus_wr_data);
        end else begin
          e = exp_q.pop_front();
          if ({bus_addr, bus_wr_data, bus_mask, bus_rdwr} !== {e, 4'hF, 1'b1}) begin
            bad++;
            $display("FAIL bus_write: got addr=%h data=%h mask=%h rdwr=%b want addr=%h data=%h mask=f rdwr=1",
                     bus_addr, bus_wr_data, bus_mask, bus_rdwr, e[63:32], e[31:0]);
          end
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1 rx_data = b; rx_valid = 1;
    @(posedge clk); #1 rx_valid = 0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
  endtask

  task automatic send_frame(input logic [31:0] len, input logic [31:0] base,
                            input logic [31:0] q[$], input logic [31:0] csum);
    send_word(len);
    send_word(base);
    foreach (q[i]) begin
      if (bus_gnt) exp_q.push_back({base + 32'(4 * i), q[i]});
      send_word(q[i]);
    end
    send_word(csum);
  endtask

  task automatic wait_end();
    int n = 0;
    while (!(done || error) && n < 300) begin @(posedge clk); #1; n++; end
    total++;
    if (!(done || error)) begin bad++; $display("FAIL wait_end: no done/error after %0d cycles", n); end
  endtask

  task automatic check_end(input string name, input logic d, input logic [2:0] code);
    total++;
    if ({done, error, cpu_hold, err_code} !== {d, !d, !d, code}) begin
      bad++;
      $display("FAIL %s: done=%b error=%b hold=%b code=%0d want done=%b error=%b hold=%b code=%0d",
               name, done, error, cpu_hold, err_code, d, !d, !d, code);
    end
    total++;
    if (exp_q.size() !== 0) begin
      bad++;
      $display("FAIL %s_writes: %0d expected writes not seen, want 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic do_restart();
    @(posedge clk); #1 restart = 1;
    @(posedge clk); #1 restart = 0;
    total++;
    if ({done, error, cpu_hold, err_code} !== {1'b0, 1'b0, 1'b1, 3'd0}) begin
      bad++;
      $display("FAIL restart: done=%b error=%b hold=%b code=%0d want 0 0 1 0", done, error, cpu_hold, err_code);
    end
  endtask

  task automatic check_reset_vals(input string name);
    total++;
    if ({bus_en, bus_rdwr, bus_mask, bus_addr, bus_wr_data, cpu_hold, done, error, err_code}
        !== {1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 3'd0}) begin
      bad++;
      $display("FAIL %s: en=%b rdwr=%b mask=%h addr=%h data=%h hold=%b done=%b err=%b code=%0d want reset values",
               name, bus_en, bus_rdwr, bus_mask, bus_addr, bus_wr_data, cpu_hold, done, error, err_code);
    end
  endtask

  task automatic test_reset();
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1 check_reset_vals("reset");
    rst_n = 1;
  endtask

  task automatic test_good();
    logic [31:0] q[$] = '{32'h11223344, 32'hA5A5A5A5};
    bus_gnt = 1;
    send_frame(2, 32'h100, q, q[0] ^ q[1]);
    wait_end();
    check_end("good", 1'b1, 3'd0);
  endtask

  task automatic test_bad_csum();
    logic [31:0] q[$] = '{32'h11223344, 32'hA5A5A5A5};
    do_restart();
    send_frame(2, 32'h100, q, 32'h0);
    wait_end();
    check_end("bad_csum", 1'b0, 3'd5);
  endtask

  task automatic test_len();
    en_seen = 0;
    do_restart();
    send_word(0);
    wait_end();
    check_end("len_zero", 1'b0, 3'd1);
    do_restart();
    send_word(8193);
    wait_end();
    check_end("len_big", 1'b0, 3'd1);
    total++;
    if (en_seen !== 1'b0) begin bad++; $display("FAIL len_bus: bus_en=%b seen, want 0", en_seen); end
  endtask

  task automatic test_align();
    do_restart();
    send_word(4);
    send_word(32'h102);
    wait_end();
    check_end("align", 1'b0, 3'd2);
  endtask

  task automatic test_overrun();
    do_restart();
    bus_gnt = 0;
    send_word(3);
    send_word(32'h200);
    send_word(32'hDEADBEEF);
    send_word(32'hCAFEF00D);
    wait_end();
    check_end("overrun", 1'b0, 3'd3);
    total++;
    if (bus_en !== 1'b0) begin bad++; $display("FAIL overrun_drop: bus_en=%b want 0", bus_en); end
  endtask

  task automatic test_same_cycle();
    logic [31:0] w0 = 32'h01020304, w1 = 32'hF0E0D0C0;
    do_restart();
    bus_gnt = 0;
    send_word(2);
    send_word(32'h300);
    exp_q.push_back({32'h300, w0});
    exp_q.push_back({32'h304, w1});
    send_word(w0);
    for (int i = 0; i < 3; i++) send_byte(w1[8*i +: 8]);
    @(posedge clk); #1 rx_data = w1[31:24]; rx_valid = 1; bus_gnt = 1;
    @(posedge clk); #1 rx_valid = 0;
    send_word(w0 ^ w1);
    wait_end();
    check_end("same_cycle", 1'b1, 3'd0);
  endtask

  task automatic test_timeout();
    int n = 0;
    do_restart();
    repeat (2 * TO) @(posedge clk);
    #1 total++;
    if (error !== 1'b0) begin bad++; $display("FAIL idle: error=%b want 0", error); end
    send_byte(8'h05);
    while (!error && n < 150) begin @(posedge clk); #1; n++; end
    total++;
    if (n < TO - 2 || n > TO + 2) begin
      bad++;
      $display("FAIL timeout_delay: error after %0d cycles want about %0d", n, TO);
    end
    check_end("timeout", 1'b0, 3'd4);
  endtask

  task automatic test_async_reset();
    do_restart();
    bus_gnt = 0;
    send_word(4);
    send_word(32'h400);
    send_word(32'h12345678);
    @(posedge clk); #1 total++;
    if ({bus_en, bus_addr, bus_wr_data} !== {1'b1, 32'h400, 32'h12345678}) begin
      bad++;
      $display("FAIL pend: en=%b addr=%h data=%h want 1 00000400 12345678", bus_en, bus_addr, bus_wr_data);
    end
    send_byte(8'hAA);
    @(posedge clk); #3 rst_n = 0;
    #1 check_reset_vals("async_reset");
    #10 rst_n = 1;
    bus_gnt = 1;
  endtask

  task automatic test_restart_after_error();
    logic [31:0] q[$] = '{32'h0BADF00D, 32'h00000001, 32'h80000000};
    send_word(0);
    wait_end();
    check_end("pre_restart", 1'b0, 3'd1);
    do_restart();
    send_frame(3, 32'h1000, q, q[0] ^ q[1] ^ q[2]);
    wait_end();
    check_end("restart_good", 1'b1, 3'd0);
  endtask

  initial begin
    test_reset();
    test_good();
    test_bad_csum();
    test_len();
    test_align();
    test_overrun();
    test_same_cycle();
    test_timeout();
    test_async_reset();
    test_restart_after_error();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
